// File: rtl/reg_file_dump_if.sv
// Address-tagged word stream from the register-file dump engine.
// The master drives words; the slave answers with ready.
interface reg_file_dump_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) ();
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_addr;

  modport master (
    output dout_valid,
    output dout_data,
    output dout_addr,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_data,
    input  dout_addr,
    output dout_ready
  );
endinterface

// File: rtl/reg_file_dump.sv
// Scans a register file two registers per read cycle through its combinational read ports
// and streams each word, tagged with its register address, over a valid/ready stream.
module reg_file_dump #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] readAdd1,
  output logic [ADDR_W-1:0] readAdd2,
  input  logic [DATA_W-1:0] out1,
  input  logic [DATA_W-1:0] out2,
  reg_file_dump_if.master   strm
);

  typedef enum logic [2:0] {StIdle, StRead, StSend0, StSend1, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastPair = ADDR_W'(NUM_REGS / 2 - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pair_q, pair_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic [ADDR_W-1:0] even_addr;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;

  assign even_addr = pair_q << 1;
  assign readAdd1  = even_addr;
  assign readAdd2  = even_addr | ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pair_q  <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    valid   = 1'b0;
    data    = '0;
    addr    = '0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          pair_d  = '0;
        end
      end
      StRead: begin
        // The whole pair is captured on one edge so both words are coherent.
        buf0_d  = out1;
        buf1_d  = out2;
        state_d = StSend0;
      end
      StSend0: begin
        valid = 1'b1;
        data  = buf0_q;
        addr  = readAdd1;
        if (strm.dout_ready) state_d = StSend1;
      end
      StSend1: begin
        valid = 1'b1;
        data  = buf1_q;
        addr  = readAdd2;
        if (strm.dout_ready) begin
          if (pair_q == LastPair) begin
            state_d = StDone;
          end else begin
            pair_d  = pair_q + ADDR_W'(1);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        pair_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy            = (state_q != StIdle);
  assign strm.dout_valid = valid;
  assign strm.dout_data  = data;
  assign strm.dout_addr  = addr;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump with a behavioural 8x16 register file behind the read ports.
module tb_reg_file_dump;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic [15:0] out1;
  logic [15:0] out2;

  reg_file_dump_if #(.ADDR_W(3), .DATA_W(16)) strm ();

  reg_file_dump #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .readAdd1 (ra1),
    .readAdd2 (ra2),
    .out1     (out1),
    .out2     (out2),
    .strm     (strm)
  );

  always #5 clk = ~clk;

  logic [15:0] regs    [8];
  logic [15:0] exp_mem [8];

  assign out1 = regs[ra1];
  assign out2 = regs[ra2];

  int          total = 0;
  int          bad   = 0;
  int          words;
  int          dones;
  logic [31:0] busy_m;
  logic [31:0] valid_m;
  logic [31:0] done_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    start           = 1'b0;
    strm.dout_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Cycle c is the c-th cycle after the edge that samples smask[0].
  task automatic run(input logic [31:0] smask, input int rlo, input int rlen, input int wcyc,
                     input int waddr, input logic [15:0] wdata, input int rcyc, input int ncyc);
    logic        stall;
    logic [15:0] pdata;
    logic [2:0]  paddr;
    stall   = 1'b0;
    pdata   = '0;
    paddr   = '0;
    words   = 0;
    dones   = 0;
    busy_m  = '0;
    valid_m = '0;
    done_m  = '0;
    start           = smask[0];
    strm.dout_ready = 1'b1;
    step();
    for (int c = 1; c <= ncyc; c++) begin
      busy_m[c]  = busy;
      valid_m[c] = strm.dout_valid;
      done_m[c]  = done;
      if (done) dones++;
      if (stall) begin
        check("hold_valid", {31'd0, strm.dout_valid}, 32'd1);
        check("hold_addr", {29'd0, strm.dout_addr}, {29'd0, paddr});
        check("hold_data", {16'd0, strm.dout_data}, {16'd0, pdata});
      end
      strm.dout_ready = !(c >= rlo && c < rlo + rlen);
      stall = strm.dout_valid && !strm.dout_ready;
      pdata = strm.dout_data;
      paddr = strm.dout_addr;
      if (strm.dout_valid && strm.dout_ready) begin
        check("word_addr", {29'd0, strm.dout_addr}, words % 8);
        check("word_data", {16'd0, strm.dout_data}, {16'd0, exp_mem[words % 8]});
        words++;
      end
      if (c == wcyc) regs[waddr] = wdata;
      start = smask[c];
      reset = (c == rcyc);
      step();
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    strm.dout_ready = 1'b1;
    regs    = '{16'd0, 16'd23584, 16'd4817, 16'd848, 16'd42, 16'd4, 16'd455, 16'd8463};
    exp_mem = '{16'd0, 16'd23584, 16'd4817, 16'd848, 16'd42, 16'd4, 16'd455, 16'd8463};
    step();
    step();
    reset = 1'b0;

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, strm.dout_valid}, 32'd0);
    check("rst_data", {16'd0, strm.dout_data}, 32'd0);
    check("rst_addr", {29'd0, strm.dout_addr}, 32'd0);
    check("rst_ra1", {29'd0, ra1}, 32'd0);
    check("rst_ra2", {29'd0, ra2}, 32'd1);

    // Plain dump, ready tied high.
    run(32'h1, 0, 0, 0, 0, 16'd0, 0, 15);
    check("t1_words", words, 8);
    check("t1_dones", dones, 1);
    check("t1_valid_cycles", valid_m, 32'h0000_1B6C);
    check("t1_busy_cycles", busy_m, 32'h0000_3FFE);
    check("t1_done_cycles", done_m, 32'h0000_2000);

    // Four-cycle stall on the SEND1 of pair 1 (cycle 6).
    run(32'h1, 6, 4, 0, 0, 16'd0, 0, 19);
    check("t2_words", words, 8);
    check("t2_dones", dones, 1);
    check("t2_valid_cycles", valid_m, 32'h0001_B7EC);
    check("t2_done_cycles", done_m, 32'h0002_0000);

    // r0 written during SEND0 of pair 0: the snapshot keeps the old value.
    run(32'h1, 0, 0, 2, 0, 16'd77, 0, 15);
    check("t3a_words", words, 8);
    regs[0] = 16'd0;

    // r5 written before pair 2 is read: the new value is streamed.
    exp_mem[5] = 16'd999;
    run(32'h1, 0, 0, 3, 5, 16'd999, 0, 15);
    check("t3b_words", words, 8);
    regs[5]    = 16'd4;
    exp_mem[5] = 16'd4;

    // Starts in cycles 3 and 13 are ignored; the one in cycle 14 launches a second dump.
    run(32'h0000_6009, 0, 0, 0, 0, 16'd0, 0, 29);
    check("t4_words", words, 16);
    check("t4_dones", dones, 2);
    check("t4_done_cycles", done_m, 32'h0800_2000);
    check("t4_idle_gap", {31'd0, busy_m[14]}, 32'd0);

    // Reset in cycle 6 abandons the dump.
    run(32'h1, 0, 0, 0, 0, 16'd0, 6, 10);
    check("t5_busy_after_rst", busy_m >> 7, 32'd0);
    check("t5_valid_after_rst", valid_m >> 7, 32'd0);
    check("t5_no_done", done_m, 32'd0);
    run(32'h1, 0, 0, 0, 0, 16'd0, 0, 15);
    check("t5_full_words", words, 8);
    check("t5_full_done", done_m, 32'h0000_2000);

    // start held high: back-to-back dumps with one idle cycle between them.
    run(32'hFFFF_FFFF, 0, 0, 0, 0, 16'd0, 0, 28);
    check("t6_words", words, 16);
    check("t6_dones", dones, 2);
    check("t6_done_cycles", done_m, 32'h0800_2000);
    check("t6_idle_gap", {30'd0, busy_m[15], busy_m[14]}, 32'd2);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
